// File: rtl/data_memory_if.sv
// Request/response bus between the CPU memory stage and data_memory.
// The master drives the request; the slave returns ready, read data and status.
interface data_memory_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  err;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    output be,
    input  ready,
    input  rdata,
    input  rvalid,
    input  err
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    input  be,
    output ready,
    output rdata,
    output rvalid,
    output err
  );

endinterface

// File: rtl/data_memory.sv
// Synchronous word-addressed data memory with registered read port.
// After reset an init sequencer loads mem[i] = i for every word, holding ready low.
// Requests whose word index is >= DEPTH are flagged with a one-cycle err pulse.
// Optional feature: define DATA_MEMORY_BYTE_WRITE_EN to honour the be strobes on
// writes; otherwise be is ignored and writes replace the whole word.
module data_memory #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  localparam int unsigned CntW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NumBytes = DATA_W / 8;
  // One extra bit so DEPTH itself is representable even if it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [CntW-1:0] CntLast  = CntW'(DEPTH - 1);

  typedef enum logic [0:0] {
    StInit,
    StIdle
  } state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [DATA_W-1:0] init_word;
  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic              rd_oor;
  logic [CntW-1:0]   idx;

  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              err_q;

  // Init value is the counter zero-extended or truncated to the word width.
  logic [CntW+DATA_W-1:0] cnt_ext;
  assign cnt_ext   = {{DATA_W{1'b0}}, cnt_q};
  assign init_word = cnt_ext[DATA_W-1:0];

  // FSM and init counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: step through every word in init, then sit in idle forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    unique case (state_q)
      StInit: begin
        init_we = 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIdle: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // Request decode; ready is a pure decode of registered state.
  assign bus.ready = (state_q == StIdle);
  assign accept    = bus.ready & bus.req;
  assign in_range  = ({1'b0, bus.addr} < DepthExt);
  assign wr_en     = accept & bus.we & in_range;
  assign rd_en     = accept & ~bus.we & in_range;
  assign rd_oor    = accept & ~bus.we & ~in_range;
  assign idx       = CntW'(bus.addr);

`ifndef DATA_MEMORY_BYTE_WRITE_EN
  // Strobes are accepted on the port but have no effect in this build.
  logic unused_be;
  assign unused_be = ^bus.be;
`endif

  // Array write port: init sequencer or accepted in-range write. Not reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[cnt_q] <= init_word;
    end else if (wr_en) begin
`ifdef DATA_MEMORY_BYTE_WRITE_EN
      for (int k = 0; k < NumBytes; k++) begin
        if (bus.be[k]) begin
          mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
        end
      end
`else
      mem[idx] <= bus.wdata;
`endif
    end
  end

  // Registered read port and status pulses; rdata holds when nothing is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_en | rd_oor;
      err_q    <= accept & ~in_range;
      if (rd_en) begin
        rdata_q <= mem[idx];
      end else if (rd_oor) begin
        rdata_q <= '0;
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: init timing, reset behaviour, a vector
// table of directed accesses and a short random phase against a reference model.
module tb_data_memory;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned DP = 1024;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;

  data_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_memory #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  exp_t        sb_q[$];
  logic [31:0] model [DP];
  logic [31:0] last_rd;

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b,
                              input logic [31:0] er, input logic ev, input logic ee);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d; v.be = b;
    v.rdata = er; v.rvalid = ev; v.err = ee;
    return v;
  endfunction

  // Drive one cycle of stimulus, then compare the response against the scoreboard.
  task automatic do_op(input vec_t v, input string nm);
    exp_t e;
    exp_t got_e;
    logic [9:0] mi;
    e.rdata = v.rdata; e.rvalid = v.rvalid; e.err = v.err;
    sb_q.push_back(e);
    bus.req = v.req; bus.we = v.we; bus.addr = v.addr; bus.wdata = v.wdata; bus.be = v.be;
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    check32({nm, ".rdata"}, bus.rdata, got_e.rdata);
    check32({nm, ".rvalid"}, {31'd0, bus.rvalid}, {31'd0, got_e.rvalid});
    check32({nm, ".err"}, {31'd0, bus.err}, {31'd0, got_e.err});
    // Keep the reference model in step with what the op should have done.
    if (v.req && !v.we) last_rd = v.rdata;
    if (v.req && v.we && v.addr < DP) begin
      mi = v.addr[9:0];
`ifdef DATA_MEMORY_BYTE_WRITE_EN
      for (int k = 0; k < 4; k++) begin
        if (v.be[k]) model[mi][8*k +: 8] = v.wdata[8*k +: 8];
      end
`else
      model[mi] = v.wdata;
`endif
    end
  endtask

  vec_t        tbl[15];
  logic [31:0] bw_exp;
  int          n_ready;
  int          rv_seen;

  initial begin
    checks  = 0;
    errors  = 0;
    last_rd = '0;
    for (int i = 0; i < DP; i++) model[i] = i;
    rst_n    = 1'b0;
    bus.req  = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.be   = '0;

    repeat (3) @(posedge clk);
    #1;
    check32("reset.ready", {31'd0, bus.ready}, 32'd0);
    check32("reset.rvalid", {31'd0, bus.rvalid}, 32'd0);
    check32("reset.err", {31'd0, bus.err}, 32'd0);
    check32("reset.rdata", bus.rdata, 32'd0);

    // Start init, then pull reset at init cycle 500 with a read request pending.
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    check32("midinit.ready_before", {31'd0, bus.ready}, 32'd0);
    rst_n    = 1'b0;
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'd5;
    #1;
    check32("midinit.ready_in_reset", {31'd0, bus.ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    n_ready = 0;
    rv_seen = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk);
      #1;
      if (bus.rvalid) rv_seen++;
      if (bus.ready) begin
        n_ready = i;
        break;
      end
    end
    bus.req = 1'b0;
    check32("init.edges_to_ready", n_ready, 32'd1024);
    check32("init.req_never_acked", rv_seen, 32'd0);
    @(posedge clk);
    #1;
    check32("init.no_late_ack", {31'd0, bus.rvalid}, 32'd0);

`ifdef DATA_MEMORY_BYTE_WRITE_EN
    bw_exp = 32'h00BB00DD;
`else
    bw_exp = 32'hAABBCCDD;
`endif
    //            req we  addr          wdata         be      rdata         rv    err
    tbl[0]  = mk(1'b1, 1'b0, 32'd0,        32'h0,        4'hF, 32'd0,        1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 32'd5,        32'h0,        4'hF, 32'd5,        1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 32'd1023,     32'h0,        4'hF, 32'd1023,     1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 32'd9,        32'h0,        4'hF, 32'd1023,     1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 32'd1,        32'h0,        4'hF, 32'd1,        1'b1, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 32'd2,        32'h0,        4'hF, 32'd2,        1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 32'd3,        32'h0,        4'hF, 32'd3,        1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 32'd7,        32'hDEADBEEF, 4'hF, 32'd3,        1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 32'd7,        32'h0,        4'hF, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b1, 32'd3,        32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 32'd3,        32'h0,        4'hF, bw_exp,       1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 32'd1024,     32'h0,        4'hF, 32'd0,        1'b1, 1'b1);
    tbl[12] = mk(1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678, 4'hF, 32'd0,        1'b0, 1'b1);
    tbl[13] = mk(1'b1, 1'b0, 32'd1023,     32'h0,        4'hF, 32'd1023,     1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 32'd0,        32'h0,        4'hF, 32'd1023,     1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      do_op(tbl[i], $sformatf("vec%0d", i));
    end

    // Random mix checked against the reference model.
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      logic oor;
      v.req   = ($urandom_range(0, 5) != 0);
      v.we    = 1'($urandom_range(0, 1));
      oor     = ($urandom_range(0, 7) == 0);
      v.addr  = oor ? (32'd1024 + 32'($urandom_range(0, 100000))) : 32'($urandom_range(0, 1023));
      v.wdata = $urandom;
      v.be    = 4'($urandom_range(0, 15));
      v.rdata = last_rd; v.rvalid = 1'b0; v.err = 1'b0;
      if (v.req) begin
        if (oor) begin
          v.err = 1'b1;
          if (!v.we) begin
            v.rvalid = 1'b1;
            v.rdata  = 32'd0;
          end
        end else if (!v.we) begin
          v.rvalid = 1'b1;
          v.rdata  = model[v.addr[9:0]];
        end
      end
      do_op(v, $sformatf("rnd%0d", i));
    end

    // Reset right after a read is accepted discards the response.
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'd5;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    check32("opreset.rvalid_before", {31'd0, bus.rvalid}, 32'd1);
    check32("opreset.rdata_before", bus.rdata, model[5]);
    rst_n = 1'b0;
    #1;
    check32("opreset.rvalid", {31'd0, bus.rvalid}, 32'd0);
    check32("opreset.rdata", bus.rdata, 32'd0);
    check32("opreset.ready", {31'd0, bus.ready}, 32'd0);
    @(posedge clk);
    #1;
    check32("opreset.rvalid_after", {31'd0, bus.rvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised synchronous data memory, the next generation of the CPU's word-addressed data store. Replaces the combinational read/write array with a clocked request interface, a registered read port with a valid strobe, out-of-range detection and a hardware init sequencer that loads each word with its own index after reset. Sits between the CPU memory stage and the load/store datapath; the core stalls on `ready`.

## Interface
- `DATA_W`, 32: data word width in bits; must be a multiple of 8.
- `DEPTH`, 1024: number of words; need not be a power of two; must be at least 2.
- `ADDR_W`, 32: width of the word index on `addr`.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  1: request strobe, sampled only while `ready`=1.
- `we`  in  1: 1 = write, 0 = read; qualified by `req`.
- `addr`  in  ADDR_W: word index, not a byte address.
- `wdata`  in  DATA_W: write data.
- `be`  in  DATA_W/8: byte write strobes; bit k selects `wdata[8k+7:8k]`.
- `ready`  out  1: memory idle and able to accept a request this cycle.
- `rdata`  out  DATA_W: registered read data.
- `rvalid`  out  1: one-cycle pulse; `rdata` is valid this cycle.
- `err`  out  1: one-cycle pulse; the accepted request had `addr` >= `DEPTH`.

## Operation
- Two-state FSM: INIT and IDLE.
- Reset (`rst_n`=0) forces INIT, clears the init counter, and sets `ready`=0, `rvalid`=0, `err`=0 and `rdata`=0. The array itself is not reset.
- INIT:
  - Each rising edge writes `mem[cnt] = cnt`, zero-extended or truncated to `DATA_W`, then increments `cnt`.
  - On the edge that writes `cnt = DEPTH-1`, the FSM moves to IDLE.
  - `req` is ignored throughout INIT.
- IDLE: `ready`=1. A request is accepted on any edge where `req`=1.
- Accepted read with `addr` < `DEPTH`:
  - On the next edge, `rdata` = `mem[addr]` and `rvalid`=1.
- Accepted write with `addr` < `DEPTH`:
  - The write is performed on that edge.
  - `rvalid` stays 0, and `rdata` holds its last value.
- Accepted request with `addr` >= `DEPTH`, compared at full `ADDR_W` width with no aliasing:
  - No array access.
  - `err`=1 for one cycle.
  - For a read, additionally `rvalid`=1 and `rdata`=0.
- With no accepted read, `rvalid` and `err` return to 0 on the next edge; `rdata` holds.
- Exactly one request per cycle, so there is no read/write port conflict.
- Write-then-read to the same address on consecutive cycles returns the new data.

## Timing
- Init latency: `ready` rises DEPTH rising edges after `rst_n` deasserts (1024 cycles by default).
- Read latency is 1: request on edge N gives `rdata`/`rvalid` valid after edge N, for the cycle up to edge N+1.
- Throughput: one request per cycle, back-to-back, with no bubbles.
- Reset asserted mid-init or mid-operation takes effect immediately:
  - All outputs drop to their reset values.
  - Init restarts from 0 on release.
  - Any in-flight read response is discarded.
- `ready` is a registered FSM decode; it has no combinational path from `req`.

## Configuration
- `DATA_MEMORY_BYTE_WRITE_EN` defined:
  - Writes update only the bytes whose `be` bit is 1.
  - `be`=0 on an accepted write leaves the word unchanged; `err` still flags an out-of-range address.
- Not defined:
  - `be` is ignored, and every accepted write replaces the full word.
  - The port remains present so that instantiations are identical in both builds.

## Test plan
- Release reset and count cycles: `ready`=0 for exactly 1024 edges, then 1. Read addr 0, 5 and 1023: `rdata` = 0, 5, 1023, each with `rvalid` one cycle after the request.
- Write 0xDEADBEEF to addr 7, then read addr 7 on the next cycle: `rdata`=0xDEADBEEF with `rvalid`=1 and `err`=0.
- Byte write: with the macro defined, write 0xAABBCCDD with `be`=4'b0101 to addr 3 (initial value 3) and read back 0x00BB00DD. Without the macro, read back 0xAABBCCDD.
- Out of range: read addr 1024, giving `err`=1, `rvalid`=1 and `rdata`=0. Then write to addr 0xFFFFFFFF: `err`=1, and a read of addr 1023 still returns 1023.
- Back-to-back: reads of addr 1, 2, 3 on consecutive cycles produce `rdata` = 1, 2, 3 on consecutive cycles with `rvalid` held at 1.
- Mid-init reset: pulse `rst_n` low at init cycle 500. `ready` stays 0 for a further 1024 edges after release, and a `req` issued during init is never acknowledged.
